// File: rtl/sig_event_capture_if.sv
// Record stream of the event capture block: head-of-FIFO record plus
// valid/ready handshake toward whoever drains it.
interface sig_event_capture_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              o_valid;
    logic              i_ready;
    logic [CH_W-1:0]   o_ch;
    logic [DATA_W-1:0] o_value;
    logic [TS_W-1:0]   o_ts;

    modport master (output o_valid, o_ch, o_value, o_ts, input i_ready);
    modport slave  (input o_valid, o_ch, o_value, o_ts, output i_ready);
endinterface

// File: rtl/sig_event_capture.sv
// Multi-channel signal event recorder: per-channel rise/fall/equal detection,
// one pending slot per channel, and a first-word-fall-through record FIFO.
module sig_event_capture #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W = $clog2(DATA_W),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] i_sig,
    input  logic                     cfg_wr,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [1:0]               cfg_mode,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [DATA_W-1:0]        cfg_val,
    sig_event_capture_if.master      rec,
    output logic [CNT_W-1:0]         o_count,
    output logic [7:0]               o_drop
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RISE  = 2'd1,
        MODE_FALL  = 2'd2,
        MODE_EQUAL = 2'd3
    } mode_t;

    mode_t             mode     [NUM_CH];
    logic [IDX_W-1:0]  idx      [NUM_CH];
    logic [DATA_W-1:0] val      [NUM_CH];
    logic [DATA_W-1:0] s_cur    [NUM_CH];
    logic [DATA_W-1:0] s_prev   [NUM_CH];
    logic [DATA_W-1:0] pend_val [NUM_CH];
    logic [TS_W-1:0]   pend_ts  [NUM_CH];

    logic [NUM_CH-1:0] pending, pending_nxt, mask, det, cfg_hit;
    logic [NUM_CH-1:0] enq_sel, granted, capture;
    logic [TS_W-1:0]   ts_cnt;
    logic [CH_W-1:0]   enq_ch;
    logic              any_pending, push, pop;
    logic [15:0]       drop_sum;
    logic [16:0]       drop_add;
    logic [7:0]        drop_nxt;

    logic [CH_W-1:0]   mem_ch    [DEPTH];
    logic [DATA_W-1:0] mem_value [DEPTH];
    logic [TS_W-1:0]   mem_ts    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    // Per-channel detection; the mask hides the first cycle after a reconfigure
    always_comb begin
        det = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode[c])
                MODE_RISE:  det[c] = !s_prev[c][idx[c]] && s_cur[c][idx[c]];
                MODE_FALL:  det[c] = s_prev[c][idx[c]] && !s_cur[c][idx[c]];
                MODE_EQUAL: det[c] = (s_cur[c] == val[c]) && (s_prev[c] != val[c]);
                default:    det[c] = 1'b0;
            endcase
            if (mask[c]) det[c] = 1'b0;
        end
    end

    always_comb begin
        enq_sel     = '0;
        enq_ch      = '0;
        any_pending = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pending[c] && !any_pending) begin
                any_pending = 1'b1;
                enq_sel[c]  = 1'b1;
                enq_ch      = CH_W'(c);
            end
        end
    end

    assign pop     = rec.o_valid && rec.i_ready;
    assign push    = any_pending && ((count < CNT_W'(DEPTH)) || pop);
    assign granted = push ? enq_sel : '0;

    // A new event is lost only when the channel's slot stays occupied this edge
    always_comb begin
        cfg_hit     = '0;
        capture     = '0;
        pending_nxt = pending;
        drop_sum    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_hit[c] = cfg_wr && (cfg_ch == CH_W'(c));
            if (granted[c] || cfg_hit[c]) pending_nxt[c] = 1'b0;
            if (det[c] && !cfg_hit[c]) begin
                if (pending[c] && !granted[c]) begin
                    drop_sum = drop_sum + 16'd1;
                end else begin
                    capture[c]     = 1'b1;
                    pending_nxt[c] = 1'b1;
                end
            end
        end
        drop_add = {9'd0, o_drop} + {1'b0, drop_sum};
        drop_nxt = (drop_add > 17'd255) ? 8'd255 : drop_add[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt  <= '0;
            pending <= '0;
            mask    <= '0;
            o_drop  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode[c]     <= MODE_OFF;
                idx[c]      <= '0;
                val[c]      <= '0;
                s_cur[c]    <= '0;
                s_prev[c]   <= '0;
                pend_val[c] <= '0;
                pend_ts[c]  <= '0;
            end
        end else begin
            ts_cnt  <= ts_cnt + 1'b1;
            pending <= pending_nxt;
            mask    <= cfg_hit;
            o_drop  <= drop_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                s_cur[c]  <= i_sig[c*DATA_W +: DATA_W];
                s_prev[c] <= s_cur[c];
                if (capture[c]) begin
                    pend_val[c] <= s_cur[c];
                    pend_ts[c]  <= ts_cnt;
                end
                if (cfg_hit[c]) begin
                    mode[c] <= mode_t'(cfg_mode);
                    idx[c]  <= cfg_idx;
                    val[c]  <= cfg_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: the head outputs are forced to zero while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ch[wr_ptr]    <= enq_ch;
            mem_value[wr_ptr] <= pend_val[enq_ch];
            mem_ts[wr_ptr]    <= pend_ts[enq_ch];
        end
    end

    assign rec.o_valid = (count != '0);
    assign rec.o_ch    = rec.o_valid ? mem_ch[rd_ptr]    : '0;
    assign rec.o_value = rec.o_valid ? mem_value[rd_ptr] : '0;
    assign rec.o_ts    = rec.o_valid ? mem_ts[rd_ptr]    : '0;
    assign o_count     = count;
endmodule

// File: tb/tb_sig_event_capture.sv
// Directed bench for sig_event_capture: a default instance and a TS_W=4
// instance share stimulus; expected records are worked out by hand.
module tb_sig_event_capture;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] sig;
    logic         cfg_wr;
    logic [1:0]   cfg_ch;
    logic [1:0]   cfg_mode;
    logic [4:0]   cfg_idx;
    logic [31:0]  cfg_val;
    logic [4:0]   count_a, count_b;
    logic [7:0]   drop_a, drop_b;
    int           total = 0;
    int           bad = 0;
    int           seen;

    sig_event_capture_if #(.NUM_CH(4), .DATA_W(32), .TS_W(16)) bus_a ();
    sig_event_capture_if #(.NUM_CH(4), .DATA_W(32), .TS_W(4))  bus_b ();

    sig_event_capture #(.NUM_CH(4), .DATA_W(32), .DEPTH(16), .TS_W(16)) dut_a (
        .clk(clk), .rst(rst), .i_sig(sig), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_idx(cfg_idx), .cfg_val(cfg_val),
        .rec(bus_a), .o_count(count_a), .o_drop(drop_a)
    );

    sig_event_capture #(.NUM_CH(4), .DATA_W(32), .DEPTH(16), .TS_W(4)) dut_b (
        .clk(clk), .rst(rst), .i_sig(sig), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_idx(cfg_idx), .cfg_val(cfg_val),
        .rec(bus_b), .o_count(count_b), .o_drop(drop_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int c, input logic [31:0] v);
        sig[c*32 +: 32] = v;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [4:0] bit_idx, input logic [31:0] value);
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_idx  = bit_idx;
        cfg_val  = value;
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic pop_a();
        bus_a.i_ready = 1'b1;
        @(negedge clk);
        bus_a.i_ready = 1'b0;
    endtask

    task automatic check_head_a(input string tag, input logic [1:0] ch,
                                input logic [31:0] value, input logic [15:0] ts);
        check_output({tag, "_valid"}, bus_a.o_valid, 1'b1);
        check_output({tag, "_ch"}, bus_a.o_ch, ch);
        check_output({tag, "_value"}, bus_a.o_value, value);
        check_output({tag, "_ts"}, bus_a.o_ts, ts);
    endtask

    initial begin
        sig           = '0;
        cfg_wr        = 1'b0;
        cfg_ch        = '0;
        cfg_mode      = '0;
        cfg_idx       = '0;
        cfg_val       = '0;
        bus_a.i_ready = 1'b0;
        bus_b.i_ready = 1'b1;
        rst           = 1'b1;
        run(2);
        check_output("rst_valid", bus_a.o_valid, 1'b0);
        check_output("rst_count", count_a, 5'd0);
        check_output("rst_drop", drop_a, 8'd0);
        check_output("rst_ch", bus_a.o_ch, 2'd0);
        check_output("rst_value", bus_a.o_value, 32'd0);
        check_output("rst_ts", bus_a.o_ts, 16'd0);
        rst = 1'b0;

        // ch1 rising edge on bit 3; the falling edge afterwards must stay silent
        cfg_write(2'd1, 2'd1, 5'd3, 32'd0);
        apply_stimulus(1, 32'h8);
        run(2);
        check_output("rise_early_valid", bus_a.o_valid, 1'b0);
        run(1);
        check_head_a("rise_rec", 2'd1, 32'h8, 16'd2);
        check_output("rise_count", count_a, 5'd1);
        pop_a();
        check_output("rise_popped_valid", bus_a.o_valid, 1'b0);
        apply_stimulus(1, 32'h0);
        run(3);
        check_output("fall_ignored_count", count_a, 5'd0);
        check_output("fall_ignored_valid", bus_a.o_valid, 1'b0);

        // ch0 equal 0xA5: a held match is one event, a re-entry is another
        cfg_write(2'd0, 2'd3, 5'd0, 32'hA5);
        apply_stimulus(0, 32'hA5);
        run(5);
        apply_stimulus(0, 32'h0);
        run(1);
        apply_stimulus(0, 32'hA5);
        run(5);
        check_output("eq_count", count_a, 5'd2);
        check_head_a("eq_rec0", 2'd0, 32'hA5, 16'd10);
        pop_a();
        check_head_a("eq_rec1", 2'd0, 32'hA5, 16'd16);
        pop_a();
        check_output("eq_drained", count_a, 5'd0);

        // ch0/ch2/ch3 rise on bit 0 at the same edge
        apply_stimulus(0, 32'h0);
        cfg_write(2'd0, 2'd1, 5'd0, 32'd0);
        cfg_write(2'd2, 2'd1, 5'd0, 32'd0);
        cfg_write(2'd3, 2'd1, 5'd0, 32'd0);
        apply_stimulus(0, 32'h1);
        apply_stimulus(2, 32'h1);
        apply_stimulus(3, 32'h1);
        run(3);
        check_output("multi_count1", count_a, 5'd1);
        run(1);
        check_output("multi_count2", count_a, 5'd2);
        run(1);
        check_output("multi_count3", count_a, 5'd3);
        check_head_a("multi_rec0", 2'd0, 32'h1, 16'd26);
        pop_a();
        check_head_a("multi_rec1", 2'd2, 32'h1, 16'd26);
        pop_a();
        check_head_a("multi_rec2", 2'd3, 32'h1, 16'd26);
        pop_a();
        check_output("multi_drained", count_a, 5'd0);

        // Backpressure: 18 ch0 events into a 16-deep FIFO with no draining
        apply_stimulus(0, 32'h0);
        for (int i = 0; i < 18; i++) begin
            run(1);
            apply_stimulus(0, 32'h1);
            run(1);
            apply_stimulus(0, 32'h0);
        end
        run(4);
        check_output("full_count", count_a, 5'd16);
        check_output("full_drop", drop_a, 8'd1);
        seen = 0;
        bus_a.i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.o_valid) seen++;
            @(negedge clk);
        end
        bus_a.i_ready = 1'b0;
        check_output("full_records", seen, 17);
        check_output("full_after_drain", count_a, 5'd0);
        check_output("full_drop_kept", drop_a, 8'd1);

        // Reset in the middle of traffic clears state before the next edge
        for (int i = 0; i < 5; i++) begin
            run(1);
            apply_stimulus(0, 32'h1);
            run(1);
            apply_stimulus(0, 32'h0);
        end
        run(4);
        check_output("mid_count", count_a, 5'd5);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_valid", bus_a.o_valid, 1'b0);
        check_output("mid_rst_count", count_a, 5'd0);
        check_output("mid_rst_drop", drop_a, 8'd0);
        check_output("mid_rst_value", bus_a.o_value, 32'd0);
        sig = '0;
        bus_b.i_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Timestamp wrap on the 4-bit instance: events stamped 15 and 17
        cfg_write(2'd0, 2'd1, 5'd0, 32'd0);
        run(13);
        apply_stimulus(0, 32'h1);
        run(1);
        apply_stimulus(0, 32'h0);
        run(1);
        apply_stimulus(0, 32'h1);
        run(4);
        check_output("wrap_count_b", count_b, 5'd2);
        check_output("wrap_ts0_b", bus_b.o_ts, 4'd15);
        check_output("wrap_ch0_b", bus_b.o_ch, 2'd0);
        check_output("wrap_ts0_a", bus_a.o_ts, 16'd15);
        bus_a.i_ready = 1'b1;
        bus_b.i_ready = 1'b1;
        @(negedge clk);
        bus_a.i_ready = 1'b0;
        bus_b.i_ready = 1'b0;
        check_output("wrap_ts1_b", bus_b.o_ts, 4'd1);
        check_output("wrap_value1_b", bus_b.o_value, 32'h1);
        check_output("wrap_ts1_a", bus_a.o_ts, 16'd17);
        check_output("wrap_count_b_after", count_b, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
